// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit.
// A single state register plus combinational next-state / control decode.
// Write enables and bad_op are gated by reset, so an in-flight access is
// dropped as soon as reset rises, without waiting for a clock edge.
//
//  state  | enc | meaning
//  -------+-----+--------------------------------------------------------
//  FETCH  |  0  | read instruction at PC, PC+4 -> PC; wait for mem_ready
//  DECODE |  1  | read registers, precompute branch target, dispatch on op
//  MEMADR |  2  | rs + sign-extended imm -> memory address (lw/sw)
//  MEMRD  |  3  | data read at ALUOut; wait for mem_ready
//  MEMWB  |  4  | load data -> rt
//  MEMWR  |  5  | data write at ALUOut; hold MemWr until mem_ready
//  EXEC   |  6  | R-type ALU operation
//  RWB    |  7  | ALU result -> rd
//  BRANCH |  8  | beq compare; PC <- target when zero
//  JUMP   |  9  | PC <- jump target
//  IEXEC  | 10  | ori: rs | zero-extended imm
//  IWB    | 11  | ALU result -> rt
//  12..15 |  -  | unused; drives nothing and returns to FETCH

module multicycle_ctrl #(
    parameter bit ORI_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWr,
    output logic       IRWr,
    output logic       MemWr,
    output logic       RegWr,
    output logic       IorD,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic       ExtOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic [3:0] state,
    output logic       bad_op
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        IEXEC  = 4'd10,
        IWB    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_RT  = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    state_t cur_state;
    state_t nxt_state;

    // Raw write enables before reset gating.
    logic pc_wr_c;
    logic ir_wr_c;
    logic mem_wr_c;
    logic reg_wr_c;
    logic bad_op_c;

    // State register: the only storage in the block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state and control decode from state, op, zero and mem_ready.
    always_comb begin
        nxt_state = FETCH;
        pc_wr_c   = 1'b0;
        ir_wr_c   = 1'b0;
        mem_wr_c  = 1'b0;
        reg_wr_c  = 1'b0;
        bad_op_c  = 1'b0;
        IorD      = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        ALUSrcA   = 1'b0;
        ExtOp     = 1'b0;
        ALUSrcB   = 2'b00;
        PCSource  = 2'b00;
        ALUOp     = ALU_ADD;

        case (cur_state)
            FETCH: begin
                ALUSrcB = 2'b01;
                pc_wr_c = mem_ready;
                ir_wr_c = mem_ready;
                nxt_state = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (op)
                    OP_RTYPE:     nxt_state = EXEC;
                    OP_LW, OP_SW: nxt_state = MEMADR;
                    OP_BEQ:       nxt_state = BRANCH;
                    OP_J:         nxt_state = JUMP;
                    OP_ORI: begin
                        if (ORI_EN) begin
                            nxt_state = IEXEC;
                        end else begin
                            bad_op_c = 1'b1;
                        end
                    end
                    default: bad_op_c = 1'b1;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ExtOp   = 1'b1;
                nxt_state = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                IorD = 1'b1;
                nxt_state = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                reg_wr_c = 1'b1;
            end
            MEMWR: begin
                IorD     = 1'b1;
                mem_wr_c = 1'b1;
                nxt_state = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_RT;
                nxt_state = RWB;
            end
            RWB: begin
                RegDst   = 1'b1;
                reg_wr_c = 1'b1;
            end
            BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALU_SUB;
                PCSource = 2'b01;
                pc_wr_c  = zero;
            end
            JUMP: begin
                PCSource = 2'b10;
                pc_wr_c  = 1'b1;
            end
            IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = ALU_OR;
                nxt_state = IWB;
            end
            IWB: begin
                reg_wr_c = 1'b1;
            end
            default: nxt_state = FETCH;
        endcase
    end

    assign PCWr   = pc_wr_c  & ~reset;
    assign IRWr   = ir_wr_c  & ~reset;
    assign MemWr  = mem_wr_c & ~reset;
    assign RegWr  = reg_wr_c & ~reset;
    assign bad_op = bad_op_c & ~reset;
    assign state  = cur_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: two instances (ori enabled / disabled), an
// instruction-level reference model producing per-cycle expectations, and a
// negedge monitor that pops and compares them.
module tb_multicycle_ctrl;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_ORI = 6'b001101;

    localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4, K_ORI = 5, K_BAD = 6;

    typedef struct packed {
        logic       pcwr;
        logic       irwr;
        logic       memwr;
        logic       regwr;
        logic       iord;
        logic       regdst;
        logic       memtoreg;
        logic       srca;
        logic       extop;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       bad;
    } ctl_t;

    typedef struct {
        int    st;
        ctl_t  ctl;
        logic  mr;
        logic  zr;
        string tag;
    } cyc_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op1, op0;
    logic       zero1, zero0, mr1, mr0;

    logic       pcwr1, irwr1, memwr1, regwr1, iord1, regdst1, memtoreg1, srca1, extop1, bad1;
    logic [1:0] srcb1, pcsrc1, aluop1;
    logic [3:0] st1;
    logic       pcwr0, irwr0, memwr0, regwr0, iord0, regdst0, memtoreg0, srca0, extop0, bad0;
    logic [1:0] srcb0, pcsrc0, aluop0;
    logic [3:0] st0;

    logic [15:0] ctl1, ctl0;
    assign ctl1 = {pcwr1, irwr1, memwr1, regwr1, iord1, regdst1, memtoreg1, srca1, extop1,
                   srcb1, pcsrc1, aluop1, bad1};
    assign ctl0 = {pcwr0, irwr0, memwr0, regwr0, iord0, regdst0, memtoreg0, srca0, extop0,
                   srcb0, pcsrc0, aluop0, bad0};

    int   errors = 0;
    int   checks = 0;
    cyc_t plan[$];
    cyc_t q1[$];
    cyc_t q0[$];

    multicycle_ctrl #(.ORI_EN(1'b1)) u1 (
        .clk(clk), .reset(reset), .op(op1), .zero(zero1), .mem_ready(mr1),
        .PCWr(pcwr1), .IRWr(irwr1), .MemWr(memwr1), .RegWr(regwr1), .IorD(iord1),
        .RegDst(regdst1), .MemtoReg(memtoreg1), .ALUSrcA(srca1), .ExtOp(extop1),
        .ALUSrcB(srcb1), .PCSource(pcsrc1), .ALUOp(aluop1), .state(st1), .bad_op(bad1)
    );

    multicycle_ctrl #(.ORI_EN(1'b0)) u0 (
        .clk(clk), .reset(reset), .op(op0), .zero(zero0), .mem_ready(mr0),
        .PCWr(pcwr0), .IRWr(irwr0), .MemWr(memwr0), .RegWr(regwr0), .IorD(iord0),
        .RegDst(regdst0), .MemtoReg(memtoreg0), .ALUSrcA(srca0), .ExtOp(extop0),
        .ALUSrcB(srcb0), .PCSource(pcsrc0), .ALUOp(aluop0), .state(st0), .bad_op(bad0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic int classify(input logic [5:0] o, input bit ori_ok);
        case (o)
            OP_R:         return K_R;
            OP_LW:        return K_LW;
            OP_SW:        return K_SW;
            OP_BEQ:       return K_BEQ;
            OP_J:         return K_J;
            OP_ORI:       return ori_ok ? K_ORI : K_BAD;
            default:      return K_BAD;
        endcase
    endfunction

    task automatic add(input int st, input ctl_t c, input logic mr, input logic zr, input string tag);
        cyc_t e;
        e.st = st; e.ctl = c; e.mr = mr; e.zr = zr; e.tag = tag;
        plan.push_back(e);
    endtask

    // Reference model: one instruction as a list of cycles, each with the
    // inputs to apply and the state/controls the instruction should show.
    task automatic build_plan(input int dut, input logic [5:0] o, input logic zbr,
                              input int fw, input int mw);
        ctl_t c;
        int   k;
        plan.delete();
        k = classify(o, dut == 1);
        for (int i = 0; i < fw; i++) begin
            c = '0; c.srcb = 2'b01;
            add(0, c, 1'b0, rb(), "fetch_wait");
        end
        c = '0; c.srcb = 2'b01; c.pcwr = 1'b1; c.irwr = 1'b1;
        add(0, c, 1'b1, rb(), "fetch");
        c = '0; c.srcb = 2'b11; c.bad = (k == K_BAD);
        add(1, c, rb(), rb(), "decode");
        case (k)
            K_R: begin
                c = '0; c.srca = 1'b1; c.aluop = 2'b10;
                add(6, c, rb(), rb(), "exec");
                c = '0; c.regdst = 1'b1; c.regwr = 1'b1;
                add(7, c, rb(), rb(), "rwb");
            end
            K_LW, K_SW: begin
                c = '0; c.srca = 1'b1; c.srcb = 2'b10; c.extop = 1'b1;
                add(2, c, rb(), rb(), "memadr");
                c = '0; c.iord = 1'b1; c.memwr = (k == K_SW);
                for (int i = 0; i < mw; i++) add(k == K_LW ? 3 : 5, c, 1'b0, rb(), "mem_wait");
                add(k == K_LW ? 3 : 5, c, 1'b1, rb(), "mem_done");
                if (k == K_LW) begin
                    c = '0; c.memtoreg = 1'b1; c.regwr = 1'b1;
                    add(4, c, rb(), rb(), "memwb");
                end
            end
            K_BEQ: begin
                c = '0; c.srca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.pcwr = zbr;
                add(8, c, rb(), zbr, "branch");
            end
            K_J: begin
                c = '0; c.pcsrc = 2'b10; c.pcwr = 1'b1;
                add(9, c, rb(), rb(), "jump");
            end
            K_ORI: begin
                c = '0; c.srca = 1'b1; c.srcb = 2'b10; c.aluop = 2'b11;
                add(10, c, rb(), rb(), "iexec");
                c = '0; c.regwr = 1'b1;
                add(11, c, rb(), rb(), "iwb");
            end
            default: ;
        endcase
    endtask

    // Applies up to maxn cycles of the plan to one instance; the other
    // instance idles in FETCH with mem_ready low and is expected to stay there.
    task automatic run_plan(input int dut, input logic [5:0] o, input int maxn);
        cyc_t idle;
        idle.st = 0; idle.ctl = '0; idle.ctl.srcb = 2'b01; idle.mr = 1'b0; idle.zr = 1'b0;
        idle.tag = "idle";
        for (int i = 0; i < plan.size() && i < maxn; i++) begin
            @(posedge clk);
            #1;
            if (dut == 1) begin
                op1 = o; mr1 = plan[i].mr; zero1 = plan[i].zr;
                op0 = 6'($urandom); mr0 = 1'b0; zero0 = rb();
                q1.push_back(plan[i]);
                q0.push_back(idle);
            end else begin
                op0 = o; mr0 = plan[i].mr; zero0 = plan[i].zr;
                op1 = 6'($urandom); mr1 = 1'b0; zero1 = rb();
                q0.push_back(plan[i]);
                q1.push_back(idle);
            end
        end
    endtask

    task automatic do_instr(input int dut, input logic [5:0] o, input logic zbr,
                            input int fw, input int mw);
        build_plan(dut, o, zbr, fw, mw);
        run_plan(dut, o, 1000);
    endtask

    // Monitor: compare whatever each instance shows this cycle against the model.
    always @(negedge clk) begin
        cyc_t e;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk($sformatf("u1 %s state", e.tag), int'(st1), e.st);
            chk($sformatf("u1 %s ctl", e.tag), int'(ctl1), int'(e.ctl));
        end
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk($sformatf("u0 %s state", e.tag), int'(st0), e.st);
            chk($sformatf("u0 %s ctl", e.tag), int'(ctl0), int'(e.ctl));
        end
    end

    initial begin
        logic [5:0] rop;
        int         sel;

        reset = 1'b1;
        op1 = OP_R; op0 = OP_R; zero1 = 1'b0; zero0 = 1'b0;
        mr1 = 1'b1; mr0 = 1'b1;
        @(posedge clk);
        #1;
        chk("rst state u1", int'(st1), 0);
        chk("rst state u0", int'(st0), 0);
        chk("rst irwr u1", int'(irwr1), 0);
        chk("rst pcwr u1", int'(pcwr1), 0);
        chk("rst pcwr u0", int'(pcwr0), 0);
        mr1 = 1'b0; mr0 = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        do_instr(1, OP_R, 1'b0, 0, 0);
        do_instr(1, OP_LW, 1'b0, 0, 3);
        do_instr(1, OP_BEQ, 1'b1, 1, 0);
        do_instr(1, OP_BEQ, 1'b0, 0, 0);
        do_instr(1, 6'b111111, 1'b0, 0, 0);
        do_instr(0, OP_ORI, 1'b0, 0, 0);
        do_instr(1, OP_ORI, 1'b0, 2, 0);
        do_instr(1, OP_J, 1'b0, 0, 0);
        do_instr(1, OP_SW, 1'b0, 1, 2);

        // Reset during a MEMWR stall.
        build_plan(1, OP_SW, 1'b0, 0, 6);
        run_plan(1, OP_SW, 5);
        @(posedge clk);
        #1;
        mr1 = 1'b0; mr0 = 1'b0;
        #2;
        chk("stall memwr", int'(memwr1), 1);
        chk("stall state", int'(st1), 5);
        reset = 1'b1;
        #1;
        chk("rst memwr drop", int'(memwr1), 0);
        chk("rst async state", int'(st1), 0);
        chk("rst regwr", int'(regwr1), 0);
        mr1 = 1'b1;
        #1;
        chk("rst irwr forced", int'(irwr1), 0);
        chk("rst pcwr forced", int'(pcwr1), 0);
        @(posedge clk);
        #1;
        chk("rst hold state", int'(st1), 0);
        chk("rst hold memwr", int'(memwr1), 0);
        mr1 = 1'b0;
        #3;
        reset = 1'b0;
        do_instr(1, OP_R, 1'b0, 1, 0);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0: rop = OP_R;
                1: rop = OP_LW;
                2: rop = OP_SW;
                3: rop = OP_BEQ;
                4: rop = OP_J;
                5: rop = OP_ORI;
                6: rop = 6'($urandom);
                default: rop = OP_ORI;
            endcase
            do_instr($urandom_range(0, 1), rop, rb(), $urandom_range(0, 3), $urandom_range(0, 4));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard drained", q1.size() + q0.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
